sd_route_ctrl: RTL
==================

# sd_route_ctrl

Sequences the core's single SPI/MMC master between the physical SD slot and the HPS-backed virtual SD image. It retargets the bus only at transaction boundaries, with a one-cycle break-before-make. It generates the optional reset-after-mount pulse and the SD activity timer that drives LED_USER/LED_DISK. It sits between emsx_top's mmc_* pins and the SD_* pins / sd_card instance.

## Interface
- ACT_TIMEOUT, 1000000: cycles sd_act stays high after the last bus edge.
- GUARD, 8: consecutive spi_cs-high cycles required before a switch.
- RST_LEN, 16: core_reset_req pulse length, in cycles.

- clk_sys  in  1  system clock (21.48 MHz domain).
- reset  in  1  synchronous, active-high; clock clk_sys. Driven by cold reset only, never by reset-after-mount.
- img_mounted  in  1  one-cycle mount strobe from hps_io.
- img_present  in  1  |img_size, sampled with img_mounted.
- reset_on_mount  in  1  status option "Reset after Mount".
- spi_sck, spi_mosi, spi_cs  in  1 each  core SPI master; cs is active-low.
- spi_miso  out  1  routed MISO to the core.
- phys_sck, phys_mosi, phys_cs  out  1 each  to the SD_* pins.
- phys_miso  in  1  from SD_MISO.
- virt_sck, virt_mosi, virt_cs  out  1 each  to sd_card.
- virt_miso  in  1  from sd_card.
- vsd_sel  out  1  1 = virtual target selected.
- sd_act  out  1  bus activity flag.
- core_reset_req  out  1  reset request ORed into the core reset.
- led_user, led_disk  out  1 each  equal to vsd_sel&sd_act and ~vsd_sel&sd_act.

## Operation
- States: ACTIVE, PENDING, BREAK.
- ACTIVE: SPI is routed combinationally to the selected target.
- Deselected target outputs: cs=1, sck=0, mosi=0.
- img_mounted with img_present != vsd_sel: latch target, go to PENDING.
- img_mounted with img_present == vsd_sel: stay in ACTIVE and clear any pending switch.
- Guard counter:
  - Increments each cycle spi_cs=1 and saturates at GUARD.
  - Clears on spi_cs=0.
- PENDING: routing is unchanged. Moves to BREAK when the guard counter equals GUARD.
- reset_on_mount=1 bypasses the guard: PENDING moves to BREAK on the next cycle.
- BREAK (exactly 1 cycle):
  - Both targets deselected; spi_miso=1.
  - vsd_sel takes the latched target at the end of the cycle.
  - Then returns to ACTIVE.
- New img_mounted during PENDING: overwrite the target. If the new target equals vsd_sel, return to ACTIVE.
- New img_mounted during BREAK: re-evaluated in ACTIVE on the next cycle against the new vsd_sel.
- Reset-after-mount: each img_mounted with reset_on_mount=1 (re)loads a counter with RST_LEN. core_reset_req is high while the counter is nonzero. This applies even when no switch occurs.
- Activity:
  - Any toggle of spi_mosi or the routed spi_miso (registered compare) clears the activity counter.
  - The counter increments and saturates at ACT_TIMEOUT.
  - sd_act = counter < ACT_TIMEOUT.

## Timing
- Reset values: state=ACTIVE, vsd_sel=0, core_reset_req=0, guard=0, activity counter=0.
- Therefore sd_act=1 for ACT_TIMEOUT cycles after reset.
- spi_miso and all target outputs are combinational from spi_* and registered vsd_sel/state, with zero latency.
- img_mounted at cycle N with the bus idle and guard saturated: PENDING at N+1, BREAK at N+2, vsd_sel flips at the N+3 edge.
- core_reset_req rises at N+1 and stays high for exactly RST_LEN cycles.
- Counter widths: $clog2(ACT_TIMEOUT+1), $clog2(GUARD+1), $clog2(RST_LEN+1).
- reset mid-PENDING or mid-BREAK: vsd_sel=0, the pending target is discarded, routing goes to the physical card.

## Structure
- Package sd_route_pkg: state enum (ACTIVE, PENDING, BREAK) and default constants for ACT_TIMEOUT, GUARD, RST_LEN.
- Sub-module sd_activity_timer:
  - Inputs: mosi, miso. Output: act.
  - Contains the edge detect and saturating counter.
  - Reused for any future floppy/IDE LED.

## Test plan
- Reset, no traffic -> sd_act=1 for 1000000 cycles, then 0. vsd_sel=0, phys_* follow spi_*, virt_cs=1.
- img_mounted, img_present=1, spi_cs held 1 for 8+ cycles -> one BREAK cycle with both cs=1 and spi_miso=1, then vsd_sel=1, virt_* follow spi_*, core_reset_req never asserted.
- img_mounted while spi_cs=0 (transfer in progress), reset_on_mount=0 -> routing unchanged until 8 cycles after spi_cs rises, then switch. No sck edge ever reaches the newly selected target before cs goes high.
- reset_on_mount=1, mount mid-transfer -> BREAK 2 cycles after the strobe regardless of cs. core_reset_req high for exactly 16 cycles. A second mount at pulse cycle 10 extends the pulse to 16 cycles from the second strobe.
- Mount img_present=1 then img_present=0 one cycle later, while pending -> returns to ACTIVE, vsd_sel stays 0, no BREAK.
- reset asserted during BREAK with target=1 -> vsd_sel=0, state=ACTIVE next cycle, phys_* routed.

Source files
------------

// File: rtl/sd_route_pkg.sv
// Shared types and default constants for the SD bus router.
package sd_route_pkg;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PENDING = 2'd1,
    BREAK   = 2'd2
  } route_state_t;

  localparam int ACT_TIMEOUT_DEF = 1000000;
  localparam int GUARD_DEF       = 8;
  localparam int RST_LEN_DEF     = 16;

endpackage

// File: rtl/sd_activity_timer.sv
// Bus activity flag: any edge on mosi/miso restarts a saturating timer.
module sd_activity_timer
  import sd_route_pkg::*;
#(
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic mosi,
  input  logic miso,
  output logic act
);

  localparam int W = $clog2(ACT_TIMEOUT + 1);
  localparam logic [W-1:0] MAX = W'(ACT_TIMEOUT);

  logic [W-1:0] cnt;
  logic         mosi_q;
  logic         miso_q;
  logic         toggle;

  assign toggle = (mosi != mosi_q) | (miso != miso_q);
  assign act    = cnt < MAX;

  // Edge history tracks the pins through reset so release is glitch-free.
  always_ff @(posedge clk_sys) begin
    mosi_q <= mosi;
    miso_q <= miso;
    if (reset)
      cnt <= '0;
    else if (toggle)
      cnt <= '0;
    else if (cnt != MAX)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/sd_route_ctrl.sv
// Routes the core SPI master to the physical or virtual SD target,
// switching only at idle boundaries with a one-cycle break.
module sd_route_ctrl
  import sd_route_pkg::*;
#(
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF,
  parameter int GUARD       = GUARD_DEF,
  parameter int RST_LEN     = RST_LEN_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic img_mounted,
  input  logic img_present,
  input  logic reset_on_mount,
  input  logic spi_sck,
  input  logic spi_mosi,
  input  logic spi_cs,
  output logic spi_miso,
  output logic phys_sck,
  output logic phys_mosi,
  output logic phys_cs,
  input  logic phys_miso,
  output logic virt_sck,
  output logic virt_mosi,
  output logic virt_cs,
  input  logic virt_miso,
  output logic vsd_sel,
  output logic sd_act,
  output logic core_reset_req,
  output logic led_user,
  output logic led_disk
);

  localparam int GW = $clog2(GUARD + 1);
  localparam int RW = $clog2(RST_LEN + 1);
  localparam logic [GW-1:0] GMAX = GW'(GUARD);
  localparam logic [RW-1:0] RMAX = RW'(RST_LEN);

  route_state_t  state;
  logic          tgt;
  logic          def_v;
  logic          def_p;
  logic [GW-1:0] guard;
  logic [RW-1:0] rst_cnt;
  logic          mnt;
  logic          pres;
  logic          brk;
  logic          to_phys;
  logic          to_virt;

  // A strobe swallowed by BREAK is replayed once back in ACTIVE.
  assign mnt  = img_mounted | def_v;
  assign pres = img_mounted ? img_present : def_p;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= ACTIVE;
      vsd_sel <= 1'b0;
      tgt     <= 1'b0;
      def_v   <= 1'b0;
      def_p   <= 1'b0;
    end else begin
      unique case (state)
        ACTIVE: begin
          def_v <= 1'b0;
          if (mnt && (pres != vsd_sel)) begin
            tgt   <= pres;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (img_mounted) begin
            tgt <= img_present;
            if (img_present == vsd_sel)
              state <= ACTIVE;
          end else if ((guard == GMAX) || reset_on_mount) begin
            state <= BREAK;
          end
        end
        BREAK: begin
          vsd_sel <= tgt;
          state   <= ACTIVE;
          if (img_mounted) begin
            def_v <= 1'b1;
            def_p <= img_present;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      guard <= '0;
    else if (!spi_cs)
      guard <= '0;
    else if (guard != GMAX)
      guard <= guard + GW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      rst_cnt <= '0;
    else if (img_mounted && reset_on_mount)
      rst_cnt <= RMAX;
    else if (rst_cnt != '0)
      rst_cnt <= rst_cnt - RW'(1);
  end

  assign core_reset_req = rst_cnt != '0;

  assign brk     = state == BREAK;
  assign to_phys = !brk && !vsd_sel;
  assign to_virt = !brk && vsd_sel;

  assign phys_cs   = to_phys ? spi_cs : 1'b1;
  assign phys_sck  = to_phys & spi_sck;
  assign phys_mosi = to_phys & spi_mosi;
  assign virt_cs   = to_virt ? spi_cs : 1'b1;
  assign virt_sck  = to_virt & spi_sck;
  assign virt_mosi = to_virt & spi_mosi;
  assign spi_miso  = brk ? 1'b1 : (vsd_sel ? virt_miso : phys_miso);

  sd_activity_timer #(
    .ACT_TIMEOUT(ACT_TIMEOUT)
  ) u_act (
    .clk_sys(clk_sys),
    .reset  (reset),
    .mosi   (spi_mosi),
    .miso   (spi_miso),
    .act    (sd_act)
  );

  assign led_user = vsd_sel & sd_act;
  assign led_disk = ~vsd_sel & sd_act;

endmodule
